// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
package booth_pkg;

  localparam int N_DEF = 8;

  // {q0, q_m1} decode values; 00 and 11 mean shift only
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_Q,
    LOAD_M,
    EVAL,
    ADD,
    SUB,
    SHIFT,
    OUT_A,
    OUT_Q
  } state_t;

endpackage

// File: rtl/booth_ctrl_iter_counter.sv
// Iteration counter: clear/enable, flags the final iteration (count == N-1).
module iter_counter #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // count shifts; the increment on the final shift wraps back to 0
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  // pre-increment value, so the exit test never sees the wrap
  assign last = (cnt == CNT_W'(N - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Moore sequencer for the Booth multiplier: load, N iterations, output A then Q.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);

  state_t state, state_nxt;
  logic   last;

  iter_counter #(.N(N), .CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == LOAD_Q),
    .en   (state == SHIFT),
    .last (last)
  );

  // state register; reset wins over start
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: EVAL samples q0/q_m1 once the previous shift has settled
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = LOAD_Q;
      LOAD_Q: state_nxt = LOAD_M;
      LOAD_M: state_nxt = EVAL;
      EVAL: begin
        case ({q0, q_m1})
          BOOTH_SUB: state_nxt = SUB;
          BOOTH_ADD: state_nxt = ADD;
          default:   state_nxt = SHIFT;
        endcase
      end
      ADD:    state_nxt = SHIFT;
      SUB:    state_nxt = SHIFT;
      SHIFT:  state_nxt = last ? OUT_A : EVAL;
      OUT_A:  state_nxt = OUT_Q;
      OUT_Q:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output decode from the state register only
  always_comb begin
    c0   = 1'b0;
    c1   = 1'b0;
    c2   = 1'b0;
    c3   = 1'b0;
    c4   = 1'b0;
    c5   = 1'b0;
    c6   = 1'b0;
    done = 1'b0;
    busy = (state != IDLE);
    unique case (state)
      LOAD_Q: c0 = 1'b1;
      LOAD_M: c1 = 1'b1;
      ADD:    c2 = 1'b1;
      SUB:    begin c2 = 1'b1; c3 = 1'b1; end
      SHIFT:  c4 = 1'b1;
      OUT_A:  c5 = 1'b1;
      OUT_Q:  begin c6 = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: builds the expected per-cycle control trace from the
// per-iteration Booth bit pairs and compares every cycle.
module tb_booth_ctrl;

  localparam int N = 8;

  // expected output vector layout {c0,c1,c2,c3,c4,c5,c6,busy,done}
  localparam logic [8:0] V_IDLE  = 9'b000000000;
  localparam logic [8:0] V_LDQ   = 9'b100000010;
  localparam logic [8:0] V_LDM   = 9'b010000010;
  localparam logic [8:0] V_EVAL  = 9'b000000010;
  localparam logic [8:0] V_ADD   = 9'b001000010;
  localparam logic [8:0] V_SUB   = 9'b001100010;
  localparam logic [8:0] V_SHIFT = 9'b000010010;
  localparam logic [8:0] V_OUTA  = 9'b000001010;
  localparam logic [8:0] V_OUTQ  = 9'b000000111;

  logic clk = 1'b0;
  logic rst, start, q0, q_m1;
  logic c0, c1, c2, c3, c4, c5, c6, busy, done;

  int nvec = 0;
  int nfail = 0;

  booth_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .q_m1(q_m1),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs_vec();
    return {c0, c1, c2, c3, c4, c5, c6, busy, done};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply. pr[k] = {q0,q_m1} seen at iteration k's EVAL.
  // pulse_iter / rst_iter: 1-based iteration at which to pulse start / assert
  // rst (0 = none). hold_start keeps start high for back-to-back operation.
  task automatic run_op(input logic [1:0] pr [N], input bit hold_start,
                        input int pulse_iter, input int rst_iter, input string name);
    logic [8:0] exp_q[$];
    logic [1:0] q_q[$];
    int it_start [N];
    int exp_done = 4;
    int n_sub_exp = 0;
    int done_at = -1;
    int n_shift = 0;
    int n_c3 = 0;
    logic [8:0] ov;

    // reference trace: IDLE(start sampled), LOAD_Q, LOAD_M, iterations, OUT_A, OUT_Q
    exp_q.push_back(V_IDLE); q_q.push_back(2'b00);
    exp_q.push_back(V_LDQ);  q_q.push_back(2'b00);
    exp_q.push_back(V_LDM);  q_q.push_back(2'b00);
    for (int k = 0; k < N; k++) begin
      it_start[k] = exp_q.size();
      exp_q.push_back(V_EVAL); q_q.push_back(pr[k]);
      if (pr[k] == 2'b10) begin
        exp_q.push_back(V_SUB); q_q.push_back(pr[k]);
        exp_done += 3; n_sub_exp++;
      end else if (pr[k] == 2'b01) begin
        exp_q.push_back(V_ADD); q_q.push_back(pr[k]);
        exp_done += 3;
      end else begin
        exp_done += 2;
      end
      exp_q.push_back(V_SHIFT); q_q.push_back(pr[k]);
    end
    exp_q.push_back(V_OUTA); q_q.push_back(2'b00);
    exp_q.push_back(V_OUTQ); q_q.push_back(2'b00);

    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      ov = obs_vec();
      chk($sformatf("%s cyc%0d", name, i), int'(ov), int'(exp_q[i]));
      if (ov[0]) done_at = i;
      if (ov[4]) n_shift++;
      if (ov[5]) n_c3++;
      {q0, q_m1} = q_q[i];
      start = (i == 0) || hold_start ||
              (pulse_iter > 0 && i == it_start[pulse_iter-1]);
      if (rst_iter > 0 && i == it_start[rst_iter-1]) begin
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("%s rst_idle", name), int'(obs_vec()), int'(V_IDLE));
        rst = 1'b0;
        return;
      end
    end
    chk($sformatf("%s done_cycle", name), done_at, exp_done);
    chk($sformatf("%s n_shift", name), n_shift, N);
    chk($sformatf("%s n_sub", name), n_c3, n_sub_exp);
  endtask

  task automatic rand_pairs(output logic [1:0] pr [N]);
    for (int k = 0; k < N; k++) pr[k] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [1:0] pr [N];

    // reset held with start high: nothing may begin
    rst = 1'b1; start = 1'b1; q0 = 1'b0; q_m1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", int'(obs_vec()), int'(V_IDLE));
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", int'(obs_vec()), int'(V_IDLE));
    end

    // shift-only: done at cycle 20
    for (int k = 0; k < N; k++) pr[k] = 2'b00;
    run_op(pr, 1'b0, 0, 0, "shift_only");

    // subtract every iteration: done at cycle 28
    for (int k = 0; k < N; k++) pr[k] = 2'b10;
    run_op(pr, 1'b0, 0, 0, "sub_all");

    // mixed pattern: done at cycle 24
    pr = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
    run_op(pr, 1'b0, 0, 0, "mixed");

    // start re-pulsed in iteration 3 is ignored
    rand_pairs(pr);
    run_op(pr, 1'b0, 3, 0, "start_ignored");

    // reset in iteration 5, then a fresh full operation
    rand_pairs(pr);
    run_op(pr, 1'b0, 0, 5, "rst_mid");
    @(negedge clk);
    chk("rst_mid idle2", int'(obs_vec()), int'(V_IDLE));
    rand_pairs(pr);
    run_op(pr, 1'b0, 0, 0, "after_rst");

    // back-to-back with start held: exactly one IDLE between operations
    rand_pairs(pr);
    run_op(pr, 1'b1, 0, 0, "b2b_1");
    rand_pairs(pr);
    run_op(pr, 1'b0, 0, 0, "b2b_2");

    // random operations
    for (int r = 0; r < 6; r++) begin
      rand_pairs(pr);
      run_op(pr, 1'b0, 0, 0, $sformatf("rand%0d", r));
    end

    @(negedge clk);
    chk("final_idle", int'(obs_vec()), int'(V_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
